register_file: RTL and testbench

Integer register file for the 64-bit RISC-V processor core: 32 architectural registers x0–x31, each 64 bits wide. It provides two combinational read ports for source operands rs1/rs2 and one clocked write port for the destination rd. It sits between instruction decode and the ALU, with write-back from the WB stage. x0 is hardwired to zero.

---
 rtl/register_file.sv | 93 +++++++++
 tb/tb_register_file.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: 32 x 64-bit integer register file for the RV64 core.
// Two combinational read ports (rs1/rs2) and one clocked write port (rd).
// x0 is hardwired to zero. Registers clear asynchronously while reset is low.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a write
// presented in the current cycle is forwarded to a read port that addresses
// the same register, before the clock edge.
`default_nettype none

module register_file #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [$clog2(NREGS)-1:0] rs1,
  input  logic [$clog2(NREGS)-1:0] rs2,
  input  logic [$clog2(NREGS)-1:0] rd,
  input  logic [XLEN-1:0]          writeData,
  input  logic                     regWrite,
  output logic [XLEN-1:0]          readData1,
  output logic [XLEN-1:0]          readData2
);

  localparam int AW = $clog2(NREGS);

  // Architectural state. Entry 0 is never written, so it always holds zero.
  logic [XLEN-1:0] regs_r [NREGS];

  // Write is qualified here so the storage block stays a plain enable.
  logic            wr_en_s;
  logic [XLEN-1:0] read1_s;
  logic [XLEN-1:0] read2_s;

  assign wr_en_s = regWrite && (rd != {AW{1'b0}});

`ifdef REGFILE_BYPASS_EN
  // A forward is only legal when the same write would land on the next edge.
  logic fwd1_s;
  logic fwd2_s;

  assign fwd1_s = reset && wr_en_s && (rs1 == rd);
  assign fwd2_s = reset && wr_en_s && (rs2 == rd);
`endif

  // Storage: async clear on reset low, single write port on the rising edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[rd] <= writeData;
    end
  end

  // Read port 1: zero for x0, optional forward, otherwise stored contents.
  always_comb begin
    read1_s = {XLEN{1'b0}};
    if (rs1 == {AW{1'b0}}) begin
      read1_s = {XLEN{1'b0}};
    end
`ifdef REGFILE_BYPASS_EN
    else if (fwd1_s) begin
      read1_s = writeData;
    end
`endif
    else begin
      read1_s = regs_r[rs1];
    end
  end

  // Read port 2: same selection as port 1, independent address.
  always_comb begin
    read2_s = {XLEN{1'b0}};
    if (rs2 == {AW{1'b0}}) begin
      read2_s = {XLEN{1'b0}};
    end
`ifdef REGFILE_BYPASS_EN
    else if (fwd2_s) begin
      read2_s = writeData;
    end
`endif
    else begin
      read2_s = regs_r[rs2];
    end
  end

  assign readData1 = read1_s;
  assign readData2 = read2_s;

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: the stimulus process pushes expected
// read-port values and raises a sample event; a separate monitor pops and
// compares shortly afterwards.
`timescale 1ns/1ps

module tb_register_file;

  localparam int XLEN = 64;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clock;
  logic            reset;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] writeData;
  logic            regWrite;
  logic [XLEN-1:0] readData1;
  logic [XLEN-1:0] readData2;

  typedef struct {
    string           name;
    logic [XLEN-1:0] e1;
    logic [XLEN-1:0] e2;
  } exp_t;

  exp_t sb_q[$];
  event chk_ev;
  int   errors = 0;
  int   checks = 0;

  register_file #(.XLEN(XLEN), .NREGS(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .writeData (writeData),
    .regWrite  (regWrite),
    .readData1 (readData1),
    .readData2 (readData2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: sample 1ns after each request and compare against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      #1;
      if (sb_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL sb_underflow: sample requested with empty scoreboard");
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (readData1 !== e.e1 || readData2 !== e.e2) begin
          errors++;
          $display("FAIL %s: got rd1=%h rd2=%h expected rd1=%h rd2=%h",
                   e.name, readData1, readData2, e.e1, e.e2);
        end
      end
    end
  end

  task automatic expect_out(input string name, input logic [XLEN-1:0] e1,
                            input logic [XLEN-1:0] e2);
    exp_t e;
    e.name = name;
    e.e1   = e1;
    e.e2   = e2;
    sb_q.push_back(e);
    -> chk_ev;
    #2;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    reset     = 1'b0;
    rs1       = 5'd1;
    rs2       = 5'd5;
    rd        = 5'd0;
    writeData = 64'd0;
    regWrite  = 1'b0;
    #1;
    expect_out("reset_low", 64'd0, 64'd0);

    // Write attempt while reset is held low must be dropped.
    regWrite  = 1'b1;
    rd        = 5'd1;
    writeData = 64'd99;
    @(posedge clock); #1;
    expect_out("write_in_reset", 64'd0, 64'd0);

    // Release and write 20 to x1 on the first edge.
    @(negedge clock);
    reset     = 1'b1;
    rd        = 5'd1;
    writeData = 64'd20;
    regWrite  = 1'b1;
    rs1       = 5'd1;
    rs2       = 5'd5;
    expect_out("x1_pre_edge", BYP ? 64'd20 : 64'd0, 64'd0);
    @(posedge clock); #1;
    expect_out("x1_post_edge", 64'd20, 64'd0);

    // Write 15 to x5, read x5 and x6.
    @(negedge clock);
    rd        = 5'd5;
    writeData = 64'd15;
    rs1       = 5'd5;
    rs2       = 5'd6;
    expect_out("x5_pre_edge", BYP ? 64'd15 : 64'd0, 64'd0);
    @(posedge clock); #1;
    expect_out("x5_post_edge", 64'd15, 64'd0);

    // Both ports on the same register.
    @(negedge clock);
    regWrite = 1'b0;
    rs1      = 5'd5;
    rs2      = 5'd5;
    expect_out("same_reg", 64'd15, 64'd15);

    // Write disabled: x7 must stay zero.
    rd        = 5'd7;
    writeData = 64'd10;
    rs1       = 5'd7;
    rs2       = 5'd1;
    @(posedge clock); #1;
    expect_out("write_disabled", 64'd0, 64'd20);

    // x0 protection, with and without bypass.
    @(negedge clock);
    regWrite  = 1'b1;
    rd        = 5'd0;
    writeData = 64'hFFFF_FFFF_FFFF_FFFF;
    rs1       = 5'd0;
    rs2       = 5'd0;
    expect_out("x0_pre_edge", 64'd0, 64'd0);
    @(posedge clock); #1;
    expect_out("x0_post_edge", 64'd0, 64'd0);

    // Bypass on x3 through both ports.
    @(negedge clock);
    rd        = 5'd3;
    writeData = 64'd42;
    rs1       = 5'd3;
    rs2       = 5'd3;
    expect_out("x3_pre_edge", BYP ? 64'd42 : 64'd0, BYP ? 64'd42 : 64'd0);
    @(posedge clock); #1;
    expect_out("x3_post_edge", 64'd42, 64'd42);

    // Top register x31 with a wide pattern.
    @(negedge clock);
    rd        = 5'd31;
    writeData = 64'hDEAD_BEEF_0123_4567;
    rs1       = 5'd31;
    rs2       = 5'd1;
    @(posedge clock); #1;
    expect_out("x31_post_edge", 64'hDEAD_BEEF_0123_4567, 64'd20);

    // Async reset between edges.
    @(negedge clock);
    regWrite = 1'b0;
    rs1      = 5'd1;
    rs2      = 5'd5;
    expect_out("before_async_reset", 64'd20, 64'd15);
    reset = 1'b0;
    expect_out("async_reset_now", 64'd0, 64'd0);
    regWrite  = 1'b1;
    rd        = 5'd5;
    writeData = 64'd77;
    @(posedge clock); #1;
    expect_out("write_held_reset", 64'd0, 64'd0);

    // Release with a pending write to x2: accepted on the first edge.
    @(negedge clock);
    reset     = 1'b1;
    rd        = 5'd2;
    writeData = 64'h55;
    rs1       = 5'd1;
    rs2       = 5'd5;
    expect_out("after_release", 64'd0, 64'd0);
    @(posedge clock); #1;
    regWrite = 1'b0;
    rs1      = 5'd2;
    rs2      = 5'd31;
    expect_out("first_write_after_release", 64'h55, 64'd0);
    rs1 = 5'd3;
    rs2 = 5'd5;
    expect_out("cleared_regs", 64'd0, 64'd0);

    #5;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending entries expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
